// File: rtl/comb_ckt_fn_pkg.sv
// Shared constants, output bundle type and population-count helper for comb_ckt_fn.
// Used by both the design and its reference model so thresholds stay in one place.
package comb_ckt_fn_pkg;

  localparam int   NUM_IN        = 6;
  localparam int   MAJ_THRESHOLD = 4;
  localparam logic RESET_VAL     = 1'b0;

  typedef struct packed {
    logic y1;
    logic y2;
    logic y3;
    logic y4;
    logic y5;
    logic temp;
  } fn_out_t;

  // Three bits are enough: at most NUM_IN = 6 ones.
  function automatic logic [2:0] pop_count(input logic [NUM_IN-1:0] code);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt = cnt + {2'b00, code[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/comb_ckt_fn_logic.sv
// Purely combinational next-value logic for Y1-Y5/temp; zero latency, no flow control.
module comb_ckt_fn_logic
  import comb_ckt_fn_pkg::*;
(
  input  logic    A,
  input  logic    B,
  input  logic    C,
  input  logic    D,
  input  logic    E,
  input  logic    F,
  output fn_out_t nxt
);

  logic temp_c;

  always_comb begin
    nxt    = '0;
    temp_c = ~(A & B) | (C ^ D);

    nxt.y1   = (A ^ B) & (C | D);
    nxt.y2   = (pop_count({A, B, C, D, E, F}) >= 3'(MAJ_THRESHOLD));
    nxt.y3   = A ^ B ^ C ^ D ^ E ^ F;
    nxt.y4   = (A & ~B) | (C & D & ~E) | F;
    // Y5 uses the unregistered term so it stays coherent with the temp output.
    nxt.y5   = temp_c & (E | F);
    nxt.temp = temp_c;
  end

endmodule

// File: rtl/comb_ckt_fn.sv
// Registered boolean-function block; 1-cycle latency, 2 with COMB_CKT_FN_INREG_EN.
// No handshake: every rising edge captures a new result; async active-low reset clears all flops.
module comb_ckt_fn
  import comb_ckt_fn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic temp
);

  logic    a_s, b_s, c_s, d_s, e_s, f_s;
  fn_out_t nxt;
  fn_out_t out_q;

`ifdef COMB_CKT_FN_INREG_EN
  logic [NUM_IN-1:0] in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= {NUM_IN{RESET_VAL}};
    end else begin
      in_q <= {A, B, C, D, E, F};
    end
  end

  assign {a_s, b_s, c_s, d_s, e_s, f_s} = in_q;
`else
  assign {a_s, b_s, c_s, d_s, e_s, f_s} = {A, B, C, D, E, F};
`endif

  comb_ckt_fn_logic u_logic (
    .A   (a_s),
    .B   (b_s),
    .C   (c_s),
    .D   (d_s),
    .E   (e_s),
    .F   (f_s),
    .nxt (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= {$bits(fn_out_t){RESET_VAL}};
    end else begin
      out_q <= nxt;
    end
  end

  assign Y1   = out_q.y1;
  assign Y2   = out_q.y2;
  assign Y3   = out_q.y3;
  assign Y4   = out_q.y4;
  assign Y5   = out_q.y5;
  assign temp = out_q.temp;

endmodule

// File: tb/tb_comb_ckt_fn.sv
// Directed and exhaustive checks for comb_ckt_fn; outputs packed as {Y1,Y2,Y3,Y4,Y5,temp}.
module tb_comb_ckt_fn;
  import comb_ckt_fn_pkg::*;

`ifdef COMB_CKT_FN_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  logic A, B, C, D, E, F;
  logic Y1, Y2, Y3, Y4, Y5, temp;
  logic [5:0] obs;

  int tests_run;
  int tests_failed;

  logic [NUM_IN-1:0] cur_code;
  logic [NUM_IN-1:0] prev_code;

  assign obs = {Y1, Y2, Y3, Y4, Y5, temp};

  comb_ckt_fn dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .Y1    (Y1),
    .Y2    (Y2),
    .Y3    (Y3),
    .Y4    (Y4),
    .Y5    (Y5),
    .temp  (temp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ref_fn(input logic [NUM_IN-1:0] code);
    logic a, b, c, d, e, f, t, maj;
    {a, b, c, d, e, f} = code;
    t   = ~(a & b) | (c ^ d);
    maj = ($countones(code) >= MAJ_THRESHOLD);
    return {(a ^ b) & (c | d), maj, ^code, (a & ~b) | (c & d & ~e) | f, t & (e | f), t};
  endfunction

  // Expected output one edge after the current drive, given the pipeline depth.
  function automatic logic [5:0] expect_next();
    return (LAT == 1) ? ref_fn(cur_code) : ref_fn(prev_code);
  endfunction

  task automatic drive(input logic [NUM_IN-1:0] code);
    {A, B, C, D, E, F} = code;
    cur_code = code;
  endtask

  task automatic tick();
    @(posedge clk);
    prev_code = cur_code;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    prev_code = '0;
    drive(6'b111111);
    #2;
    tests_run++;
    if (obs !== {6{RESET_VAL}}) begin
      tests_failed++;
      $display("FAIL reset_async: got %b want %b", obs, {6{RESET_VAL}});
    end
    tick();
    tests_run++;
    if (obs !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_held_edge: got %b want %b", obs, 6'b000000);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    prev_code = '0;
`ifdef COMB_CKT_FN_INREG_EN
    tick();
    tests_run++;
    if (obs !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_release_inreg_zero: got %b want %b", obs, 6'b000001);
    end
    tick();
`else
    tick();
`endif
    tests_run++;
    if (obs !== 6'b010100) begin
      tests_failed++;
      $display("FAIL reset_release_111111: got %b want %b", obs, 6'b010100);
    end
  endtask

  task automatic test_directed();
    logic [5:0] codes [6];
    logic [5:0] exps  [6];
    codes = '{6'b000000, 6'b101101, 6'b100000, 6'b111000, 6'b000111, 6'b110011};
    exps  = '{6'b000001, 6'b110111, 6'b001101, 6'b001001, 6'b001111, 6'b010100};
    for (int i = 0; i < 6; i++) begin
      drive(codes[i]);
      repeat (LAT) tick();
      tests_run++;
      if (obs !== exps[i]) begin
        tests_failed++;
        $display("FAIL directed_%b: got %b want %b", codes[i], obs, exps[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(6'b101101);
    repeat (LAT) tick();
    #2;
    drive(6'b010010);
    #1;
    tests_run++;
    if (obs !== 6'b110111) begin
      tests_failed++;
      $display("FAIL hold_between_edges: got %b want %b", obs, 6'b110111);
    end
    repeat (LAT) tick();
    tests_run++;
    if (obs !== 6'b000011) begin
      tests_failed++;
      $display("FAIL hold_next_010010: got %b want %b", obs, 6'b000011);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] exp;
    for (int i = 0; i < 64; i++) begin
      drive(6'(i));
      exp = expect_next();
      tick();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL sweep_%0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_pulse();
    logic [5:0] codes [4];
    logic [5:0] exp;
    codes = '{6'b101101, 6'b100000, 6'b000111, 6'b111111};
    for (int i = 50; i < 54; i++) begin
      drive(6'(i));
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 6'b000000) begin
      tests_failed++;
      $display("FAIL pulse_clear: got %b want %b", obs, 6'b000000);
    end
    #1;
    rst_n     = 1'b1;
    prev_code = '0;
    for (int k = 0; k < 4; k++) begin
      drive(codes[k]);
      exp = expect_next();
      tick();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL pulse_resume_%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cur_code     = '0;
    prev_code    = '0;
    test_reset();
    test_directed();
    test_hold();
    test_sweep();
    test_reset_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
